// File: rtl/ddr3_port_arbiter_if.sv
// Client and DDR3-bridge signal bundle for the two-port DDR3 arbiter.
// The slave modport is the arbiter's view; the master modport drives clients and bridge.
interface ddr3_port_arbiter_if;
  logic         c0_req;
  logic         c1_req;
  logic         c0_we;
  logic         c1_we;
  logic [31:0]  c0_addr;
  logic [31:0]  c1_addr;
  logic [127:0] c0_wdata;
  logic [127:0] c1_wdata;
  logic         c0_ack;
  logic         c1_ack;
  logic [127:0] c0_rdata;
  logic [127:0] c1_rdata;
  logic         c0_err;
  logic         c1_err;
  logic [31:0]  sdram_address;
  logic         rd_en;
  logic         wr_en;
  logic [127:0] write_data_input;
  logic [127:0] read_data;
  logic         write_complete;
  logic         read_complete;
  logic         timeout_err;

  modport slave (
    input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  read_data, write_complete, read_complete,
    output c0_ack, c1_ack, c0_rdata, c1_rdata, c0_err, c1_err,
    output sdram_address, rd_en, wr_en, write_data_input, timeout_err
  );

  modport master (
    output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
    output read_data, write_complete, read_complete,
    input  c0_ack, c1_ack, c0_rdata, c1_rdata, c0_err, c1_err,
    input  sdram_address, rd_en, wr_en, write_data_input, timeout_err
  );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Two-client round-robin arbiter in front of a DDR3 bridge, one transaction at a time,
// with a BUSY watchdog that acks the client with an error if the bridge never completes.
module ddr3_port_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst,
  ddr3_port_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrates and latches the winner's command
  // BUSY  | command held on the bridge until matching completion or timeout
  // DONE  | one-cycle ack to the granted client
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   addr_q, addr_d;
  logic [127:0]  wdata_q, wdata_d;
  logic          c0_ack_q, c0_ack_d;
  logic          c1_ack_q, c1_ack_d;
  logic          c0_err_q, c0_err_d;
  logic          c1_err_q, c1_err_d;
  logic [127:0]  c0_rdata_q, c0_rdata_d;
  logic [127:0]  c1_rdata_q, c1_rdata_d;
  logic          timeout_err_q, timeout_err_d;
  logic          grant_c1;
  logic          match;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    rd_en_d       = rd_en_q;
    wr_en_d       = wr_en_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    c0_ack_d      = 1'b0;
    c1_ack_d      = 1'b0;
    c0_err_d      = 1'b0;
    c1_err_d      = 1'b0;
    c0_rdata_d    = c0_rdata_q;
    c1_rdata_d    = c1_rdata_q;
    timeout_err_d = timeout_err_q;
    cnt_inc       = cnt_q + CW'(1);
    // On a tie the client that did not win last time is served
    grant_c1      = bus.c1_req && (!bus.c0_req || !last_grant_q);
    match         = we_q ? bus.write_complete : bus.read_complete;

    case (state_q)
      IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          gnt_d        = grant_c1;
          last_grant_d = grant_c1;
          we_d         = grant_c1 ? bus.c1_we    : bus.c0_we;
          addr_d       = grant_c1 ? bus.c1_addr  : bus.c0_addr;
          wdata_d      = grant_c1 ? bus.c1_wdata : bus.c0_wdata;
          wr_en_d      = we_d;
          rd_en_d      = !we_d;
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        // A completion landing on the timeout cycle still counts as a normal ack
        if (match || (cnt_inc == CW'(TIMEOUT))) begin
          state_d  = DONE;
          rd_en_d  = 1'b0;
          wr_en_d  = 1'b0;
          c0_ack_d = !gnt_q;
          c1_ack_d = gnt_q;
          if (!match) begin
            c0_err_d      = !gnt_q;
            c1_err_d      = gnt_q;
            timeout_err_d = 1'b1;
          end else if (!we_q) begin
            if (gnt_q) c1_rdata_d = bus.read_data;
            else       c0_rdata_d = bus.read_data;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      we_q          <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      c0_ack_q      <= 1'b0;
      c1_ack_q      <= 1'b0;
      c0_err_q      <= 1'b0;
      c1_err_q      <= 1'b0;
      c0_rdata_q    <= '0;
      c1_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      c0_ack_q      <= c0_ack_d;
      c1_ack_q      <= c1_ack_d;
      c0_err_q      <= c0_err_d;
      c1_err_q      <= c1_err_d;
      c0_rdata_q    <= c0_rdata_d;
      c1_rdata_q    <= c1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.rd_en            = rd_en_q;
  assign bus.wr_en            = wr_en_q;
  assign bus.sdram_address    = addr_q;
  assign bus.write_data_input = wdata_q;
  assign bus.c0_ack           = c0_ack_q;
  assign bus.c1_ack           = c1_ack_q;
  assign bus.c0_err           = c0_err_q;
  assign bus.c1_err           = c1_err_q;
  assign bus.c0_rdata         = c0_rdata_q;
  assign bus.c1_rdata         = c1_rdata_q;
  assign bus.timeout_err      = timeout_err_q;

endmodule
